// File: rtl/pc_pkg.sv
// Shared constants and the command encoding used by the fetch unit and its
// return-address stack.
package pc_pkg;

    localparam int          DEF_ADDR_W    = 32;
    localparam int          DEF_STEP      = 4;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam int          DEF_RAS_DEPTH = 8;

    typedef enum logic [2:0] {
        CMD_SEQ   = 3'd0,
        CMD_REDIR = 3'd1,
        CMD_CALL  = 3'd2,
        CMD_RET   = 3'd3,
        CMD_HOLD  = 3'd4
    } cmd_e;

    // Priority: pause > call > ret > redirect > sequential.
    function automatic cmd_e decode_cmd(
        input logic pause,
        input logic call,
        input logic ret,
        input logic redirect
    );
        cmd_e cmd;
        if (pause) begin
            cmd = CMD_HOLD;
        end else if (call) begin
            cmd = CMD_CALL;
        end else if (ret) begin
            cmd = CMD_RET;
        end else if (redirect) begin
            cmd = CMD_REDIR;
        end else begin
            cmd = CMD_SEQ;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty is ignored; both report a one-cycle event pulse.
module pc_ras
    import pc_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_RAS_DEPTH
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  sp_r;
    logic [CNT_W-1:0]  count_r;
    logic              overflow_r;
    logic              underflow_r;
    logic              full_s;
    logic              empty_s;
    logic [PTR_W-1:0]  top_idx_s;

    // sp_r is the next free slot; when full it also points at the oldest entry.
    assign full_s    = (count_r == CNT_MAX);
    assign empty_s   = (count_r == {CNT_W{1'b0}});
    assign top_idx_s = sp_r - PTR_W'(1'b1);

    assign top       = mem_r[top_idx_s];
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

    // Stack pointer, occupancy and event pulses.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp_r        <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            if (push) begin
                sp_r <= sp_r + PTR_W'(1'b1);
                if (full_s) begin
                    overflow_r <= 1'b1;
                end else begin
                    count_r <= count_r + CNT_W'(1'b1);
                end
            end else if (pop) begin
                if (empty_s) begin
                    underflow_r <= 1'b1;
                end else begin
                    sp_r    <= top_idx_s;
                    count_r <= count_r - CNT_W'(1'b1);
                end
            end
        end
    end

    // Entry storage; validity is tracked by count_r so no reset is needed.
    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem_r[sp_r] <= push_data;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Program-counter generator: priority command decode, target alignment,
// next-PC selection and the PC register, backed by a return-address stack.
module pc_fetch_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter int                STEP      = DEF_STEP,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(DEF_RESET_VEC),
    parameter int                RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             pause,
    input  logic                             redirect,
    input  logic                             call,
    input  logic                             ret,
    input  logic [ADDR_W-1:0]                target,
    output logic [ADDR_W-1:0]                instruction_address,
    output logic [$clog2(RAS_DEPTH+1)-1:0]   ras_count,
    output logic                             ras_empty,
    output logic                             ras_full,
    output logic                             ras_overflow,
    output logic                             ras_underflow
);

    localparam logic [ADDR_W-1:0] STEP_V     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP_V - ADDR_W'(1'b1));
    localparam logic [ADDR_W-1:0] RESET_PC   = RESET_VEC & ALIGN_MASK;

    cmd_e              cmd_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_next_s;
    logic [ADDR_W-1:0] seq_pc_s;
    logic [ADDR_W-1:0] target_aligned_s;
    logic [ADDR_W-1:0] ras_top_s;
    logic              ras_empty_s;
    logic              push_s;
    logic              pop_s;

    assign seq_pc_s         = pc_r + STEP_V;
    assign target_aligned_s = target & ALIGN_MASK;

    // Command decode and next-PC selection; an empty-stack return falls through to sequential.
    always_comb begin
        cmd_s     = decode_cmd(pause, call, ret, redirect);
        pc_next_s = seq_pc_s;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        case (cmd_s)
            CMD_HOLD: begin
                pc_next_s = pc_r;
            end
            CMD_CALL: begin
                pc_next_s = target_aligned_s;
                push_s    = 1'b1;
            end
            CMD_RET: begin
                pop_s = 1'b1;
                if (ras_empty_s) begin
                    pc_next_s = seq_pc_s;
                end else begin
                    pc_next_s = ras_top_s;
                end
            end
            CMD_REDIR: begin
                pc_next_s = target_aligned_s;
            end
            CMD_SEQ: begin
                pc_next_s = seq_pc_s;
            end
            default: begin
                pc_next_s = seq_pc_s;
            end
        endcase
    end

    // Program-counter register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= pc_next_s;
        end
    end

    assign instruction_address = pc_r;
    assign ras_empty           = ras_empty_s;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (seq_pc_s),
        .top       (ras_top_s),
        .count     (ras_count),
        .full      (ras_full),
        .empty     (ras_empty_s),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a queue-based reference model predicts
// each cycle's PC and stack state; a monitor compares after every clock edge.
module tb_pc_fetch_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        pause, redirect, call, ret;
    logic [31:0] target;
    logic [31:0] instruction_address;
    logic [3:0]  ras_count;
    logic        ras_empty, ras_full, ras_overflow, ras_underflow;

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] ras_q[$];
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_fail   = 0;

    always #5 clock = ~clock;

    pc_fetch_unit dut (
        .clock               (clock),
        .reset               (reset),
        .pause               (pause),
        .redirect            (redirect),
        .call                (call),
        .ret                 (ret),
        .target              (target),
        .instruction_address (instruction_address),
        .ras_count           (ras_count),
        .ras_empty           (ras_empty),
        .ras_full            (ras_full),
        .ras_overflow        (ras_overflow),
        .ras_underflow       (ras_underflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge: drive one command, predict its result, wait one cycle.
    task automatic step(input logic p, input logic c, input logic r, input logic rd,
                        input logic [31:0] t);
        exp_t e;
        pause = p; call = c; ret = r; redirect = rd; target = t;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        if (!p) begin
            if (c) begin
                if (ras_q.size() == 8) begin
                    void'(ras_q.pop_front());
                    e.ovf = 1'b1;
                end
                ras_q.push_back(m_pc + 32'd4);
                m_pc = t & 32'hFFFF_FFFC;
            end else if (r) begin
                if (ras_q.size() == 0) begin
                    e.unf = 1'b1;
                    m_pc  = m_pc + 32'd4;
                end else begin
                    m_pc = ras_q.pop_back();
                end
            end else if (rd) begin
                m_pc = t & 32'hFFFF_FFFC;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
        e.pc  = m_pc;
        e.cnt = 4'(ras_q.size());
        sb.push_back(e);
        @(negedge clock);
    endtask

    // Monitor: compare every registered output one delta after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pc",        instruction_address, e.pc);
                check("ras_count", 32'(ras_count), 32'(e.cnt));
                check("ras_empty", 32'(ras_empty), 32'(e.cnt == 4'd0));
                check("ras_full",  32'(ras_full),  32'(e.cnt == 4'd8));
                check("overflow",  32'(ras_overflow),  32'(e.ovf));
                check("underflow", 32'(ras_underflow), 32'(e.unf));
            end
        end
    end

    initial begin
        reset = 1'b0;
        pause = 1'b0; call = 1'b0; ret = 1'b0; redirect = 1'b0; target = 32'h0;
        m_pc = 32'h0;
        #2;
        check("reset_pc",    instruction_address, 32'h0);
        check("reset_count", 32'(ras_count), 32'h0);
        check("reset_empty", 32'(ras_empty), 32'h1);
        check("reset_pulses", {30'h0, ras_overflow, ras_underflow}, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Idle counting: 4, 8, 12.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Call / ret round trip from 0x100.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_2003);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Nine calls overflow once; nine rets drain in LIFO order then underflow.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h1000 + 32'(i) * 32'h40);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Wrap at the top of the address space, and a call that pushes 0.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0500);
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);

        // Three deep, then asynchronous reset between edges.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h300 + 32'(i) * 32'h100);
        check("pre_reset_count", 32'(ras_count), 32'd3);
        pause = 1'b0; call = 1'b0; ret = 1'b0; redirect = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_pc",    instruction_address, 32'h0);
        check("async_count", 32'(ras_count), 32'h0);
        check("async_empty", 32'(ras_empty), 32'h1);
        m_pc = 32'h0;
        ras_q.delete();
        @(negedge clock);
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Pause dominates call and redirect; call taken once pause drops.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040);
        step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0800);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0800);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0800);

        // Randomized mix with overlapping commands.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom());
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clock);
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the program-counter width in bits.
REQ-002 The block SHALL have parameter STEP, default 4, meaning the sequential increment in bytes; it must be a power of two and at least 1.
REQ-003 The block SHALL have parameter RESET_VEC, default 0, meaning the first fetch address after reset.
REQ-004 The block SHALL have parameter RAS_DEPTH, default 8, meaning the number of return-address-stack entries; it must be a power of two and at least 2.
REQ-005 clock  in  1  sole clock; all state updates on the posedge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 pause  in  1  freezes all state this cycle.
REQ-008 redirect  in  1  taken branch or jump to target.
REQ-009 call  in  1  jump to target and push the return address.
REQ-010 ret  in  1  jump to the address popped from the return-address stack.
REQ-011 target  in  ADDR_W  destination for redirect and call.
REQ-012 instruction_address  out  ADDR_W  current fetch address (registered).
REQ-013 ras_count  out  $clog2(RAS_DEPTH+1)  number of valid stack entries.
REQ-014 ras_empty, ras_full  out  1 each  ras_empty = (count==0); ras_full = (count==RAS_DEPTH).
REQ-015 ras_overflow, ras_underflow  out  1 each  registered one-cycle event pulses.

Function
REQ-016 Each cycle the block SHALL apply the highest-priority active input: pause, then call, then ret, then redirect, then sequential increment.
REQ-017 pause SHALL hold instruction_address, the stack and ras_count unchanged, and SHALL drive both event pulses low that cycle.
REQ-018 Sequential operation SHALL set instruction_address to instruction_address+STEP, modulo 2^ADDR_W; all-ones-region addresses wrap to 0 with no flag.
REQ-019 redirect SHALL load target with its low log2(STEP) bits forced to zero.
REQ-020 call SHALL load the aligned target and push instruction_address+STEP (modulo 2^ADDR_W) in the same cycle.
REQ-021 A call when ras_full=1 SHALL overwrite the oldest entry (circular), keep ras_count at RAS_DEPTH, and pulse ras_overflow for one cycle.
REQ-022 ret with ras_empty=0 SHALL load the top entry, pop it and decrement ras_count.
REQ-023 ret with ras_empty=1 SHALL fall back to the sequential increment, leave the stack unchanged, and pulse ras_underflow for one cycle.
REQ-024 An address SHALL appear on instruction_address exactly one cycle after its command (no combinational input-to-output path).
REQ-025 Stack entries SHALL store full ADDR_W values; each is already aligned because the PC stays aligned.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force instruction_address=RESET_VEC (aligned), ras_count=0, the stack pointer to 0, and both event pulses to 0.
REQ-027 The first posedge after reset deasserts SHALL follow normal priority; with no commands, instruction_address becomes RESET_VEC+STEP.
REQ-028 Reset asserted mid-operation SHALL discard all stack contents; stack-entry storage itself needs no reset.

Structure
REQ-029 Package pc_pkg SHALL hold the default parameter constants and a command enum (CMD_SEQ, CMD_REDIR, CMD_CALL, CMD_RET, CMD_HOLD) produced by the priority decoder.
REQ-030 Sub-module pc_ras SHALL implement the circular return-address stack: push, pop, top, count, full/empty and overflow/underflow detection.
REQ-031 pc_fetch_unit SHALL contain only the priority decode, alignment, the next-PC mux and the PC register.

Verification
REQ-032 Reset with defaults, then 3 idle cycles -> instruction_address 0, 4, 8, 12.
REQ-033 PC=0x100, call target=0x2003, then ret two cycles later -> PC 0x2000, 0x2004, then 0x104; ras_count goes 1 then 0.
REQ-034 Nine consecutive calls at RAS_DEPTH=8 -> ras_overflow pulses on the ninth only; eight rets then return the 2nd..9th return addresses in LIFO order; a ninth ret pulses ras_underflow and the PC increments.
REQ-035 pause, call and redirect all high at PC=0x40 -> PC stays 0x40 and ras_count is unchanged; releasing pause with call still high -> call is taken.
REQ-036 PC=0xFFFFFFFC idle -> 0x00000000; call at 0xFFFFFFFC pushes 0x00000000.
REQ-037 Reset asserted asynchronously between edges with ras_count=3 -> instruction_address=RESET_VEC and ras_count=0 immediately, before the next clock edge.
